ps2_key_tracker: RTL
====================

// Module: ps2_key_tracker
// PURPOSE
//  Consumes scan-code bytes from ps2_keyboard via its ready/nextdata_n handshake and decodes PS/2 set-2
//  make, break (F0) and extended (E0) sequences. Tracks the held key, counts presses and drives
//  seven-segment digits showing the key code and press count. Sits between ps2_keyboard and the board
//  seg/ledr outputs in top.
// PARAMETERS
//  CNT_W            8  press counter width
//  CNT_DIGITS       2  seg digits for press_cnt; CNT_DIGITS*4 >= CNT_W (elaboration error otherwise)
//  BLANK_ON_RELEASE 1  1: key-code digits blank while no key held; 0: show last key code
//  TYPEMATIC_COUNT  0  1: repeated make of held key counts and pulses make; 0: repeats ignored
// PORTS
//  clk         in   1                 system clock
//  rst         in   1                 synchronous, active-high reset
//  ready       in   1                 ps2_keyboard FIFO non-empty
//  data        in   8                 ps2_keyboard FIFO head byte
//  overflow    in   1                 ps2_keyboard FIFO overflow
//  nextdata_n  out  1                 active-low pop strobe to ps2_keyboard
//  key_code    out  8                 code of last make/break
//  key_ext     out  1                 last key was E0-prefixed
//  key_held    out  1                 tracked key currently down
//  make_pulse  out  1                 1-cycle strobe on counted make
//  break_pulse out  1                 1-cycle strobe on any break
//  press_cnt   out  CNT_W             counted presses, wraps
//  ovf_sticky  out  1                 overflow seen since reset
//  seg         out  8*(2+CNT_DIGITS)  active-low digits, digit i = seg[8i+7:8i]
// BEHAVIOUR
//  Reset: nextdata_n=1, key_code=0, key_ext=0, key_held=0, pulses=0, press_cnt=0, ovf_sticky=0, FSM=IDLE;
//   seg: key digits 8'hFF (blank), count digits "0" (8'h03).
//  Handshake: at edge T with ready=1 & nextdata_n=1 -> byte consumed; nextdata_n=0 during T+1 only,
//   forced 1 at T+2. Max one byte per 2 cycles. No consume while rst=1.
//  Latency: decoded outputs registered, valid in T+1; seg combinational from those registers.
//  FSM on consumed byte b:
//   IDLE:    E0->EXT; F0->BRK; else make(b,0)->IDLE
//   EXT:     F0->EXT_BRK; E0->EXT; else make(b,1)->IDLE
//   BRK:     E0->EXT; F0->BRK; else break(b,0)->IDLE
//   EXT_BRK: E0->EXT; F0->EXT_BRK; else break(b,1)->IDLE
//   00,FF,AA,FA,FE: discarded in any state -> IDLE, no outputs change.
//  make(c,e): if key_held & key_code==c & key_ext==e -> repeat: counted only if TYPEMATIC_COUNT.
//   Otherwise (or counted repeat): key_code=c, key_ext=e, key_held=1, make_pulse=1, press_cnt+1.
//   New key while another held replaces it.
//  break(c,e): break_pulse=1 always; key_held=0 only if c,e match the tracked key; key_code unchanged.
//  press_cnt wraps 2^CNT_W-1 -> 0. ovf_sticky set on overflow=1, cleared only by rst.
//  seg: digit0/1 = key_code[3:0]/[7:4]; digits 2.. = press_cnt nibbles (zero-extended).
//   Key digits 8'hFF before first make and, if BLANK_ON_RELEASE, while key_held=0.
//   Active-high a,b,c,d,e,f,g,dp table, output inverted, dp off:
//   0 FC 1 60 2 DA 3 F2 4 66 5 B6 6 BE 7 E0 8 FE 9 F6 A EE b 3E C 9C d 7A E 9E F 8E
// STRUCTURE
//  ps2_pkg: scan constants (E0, F0, discard codes), FSM state encoding, hex-to-seg table.
//  Sub-module hex7seg (4-bit in, 8-bit active-low out), one instance per digit via generate.
// TESTING
//  1 rst; byte 1C -> T+1 nextdata_n=0, key_code=1C, key_held=1, make_pulse=1, press_cnt=1,
//    seg[7:0]=8'h63, seg[15:8]=8'h9F, seg[23:16]=8'h9F
//  2 then F0,1C -> break_pulse=1, key_held=0, seg[15:0]=16'hFFFF, press_cnt=1
//  3 E0,75 then E0,F0,75 -> key_ext=1, key_code=75, held=1, cnt+1; then held=0, break_pulse=1
//  4 1C,1C,1C: TYPEMATIC_COUNT=0 -> press_cnt=1, one make_pulse; =1 -> press_cnt=3, three pulses
//  5 CNT_W=8: 256 distinct-key makes -> press_cnt=0, count digits 8'h03
//  6 ready held 1 with 3 bytes -> nextdata_n 1,0,1,0,1,0; rst after E0 then 75 -> key_ext=0;
//    overflow pulse -> ovf_sticky=1 until rst

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key tracker: set-2 prefix codes, discard codes,
// decoder state encoding and the hex-to-seven-segment pattern table.
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    // Keyboard status/ack bytes that never form part of a key sequence
    function automatic logic is_discard(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF) || (b == 8'hAA) ||
               (b == 8'hFA) || (b == 8'hFE);
    endfunction

    // Active-high segment pattern, bit order a,b,c,d,e,f,g,dp (a is the MSB)
    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hFC;
            4'h1: s = 8'h60;
            4'h2: s = 8'hDA;
            4'h3: s = 8'hF2;
            4'h4: s = 8'h66;
            4'h5: s = 8'hB6;
            4'h6: s = 8'hBE;
            4'h7: s = 8'hE0;
            4'h8: s = 8'hFE;
            4'h9: s = 8'hF6;
            4'hA: s = 8'hEE;
            4'hB: s = 8'h3E;
            4'hC: s = 8'h9C;
            4'hD: s = 8'h7A;
            4'hE: s = 8'h9E;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// One hexadecimal digit to an active-low seven-segment pattern, decimal point off.
module hex7seg
    import ps2_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg_n
);

    assign seg_n = ~hex_to_seg(hex);

endmodule

// File: rtl/ps2_key_tracker.sv
// Pops scan-code bytes from ps2_keyboard, decodes set-2 make/break/extended sequences,
// tracks the held key and press count, and drives seven-segment digits for both.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int CNT_W            = 8,
    parameter int CNT_DIGITS       = 2,
    parameter int BLANK_ON_RELEASE = 1,
    parameter int TYPEMATIC_COUNT  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ready,
    input  logic [7:0]                  data,
    input  logic                        overflow,
    output logic                        nextdata_n,
    output logic [7:0]                  key_code,
    output logic                        key_ext,
    output logic                        key_held,
    output logic                        make_pulse,
    output logic                        break_pulse,
    output logic [CNT_W-1:0]            press_cnt,
    output logic                        ovf_sticky,
    output logic [8*(2+CNT_DIGITS)-1:0] seg
);

    localparam int NDIG = 2 + CNT_DIGITS;

    if (CNT_DIGITS * 4 < CNT_W) begin : g_bad_digits
        $error("CNT_DIGITS too small to display CNT_W bits of press_cnt");
    end

    logic [1:0]       state_q, state_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic [7:0]       key_code_q, key_code_d;
    logic             key_ext_q, key_ext_d;
    logic             key_held_q, key_held_d;
    logic             key_valid_q, key_valid_d;
    logic             make_pulse_q, make_pulse_d;
    logic             break_pulse_q, break_pulse_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             ovf_sticky_q, ovf_sticky_d;

    logic consume;
    logic do_make;
    logic do_break;
    logic ev_ext;
    logic same_key;

    // A byte is taken only while the pop strobe is idle, so the strobe alternates at most every other cycle
    always_comb begin
        consume       = ready && nextdata_n_q;
        nextdata_n_d  = !consume;
        state_d       = state_q;
        key_code_d    = key_code_q;
        key_ext_d     = key_ext_q;
        key_held_d    = key_held_q;
        key_valid_d   = key_valid_q;
        press_cnt_d   = press_cnt_q;
        make_pulse_d  = 1'b0;
        break_pulse_d = 1'b0;
        ovf_sticky_d  = ovf_sticky_q || overflow;
        do_make       = 1'b0;
        do_break      = 1'b0;
        ev_ext        = 1'b0;

        if (consume) begin
            if (is_discard(data)) begin
                state_d = ST_IDLE;
            end else if (data == SC_EXT) begin
                state_d = ST_EXT;
            end else if (data == SC_BRK) begin
                state_d = (state_q == ST_EXT || state_q == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
            end else begin
                state_d  = ST_IDLE;
                ev_ext   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
                do_make  = (state_q == ST_IDLE) || (state_q == ST_EXT);
                do_break = !do_make;
            end
        end

        same_key = key_held_q && (key_code_q == data) && (key_ext_q == ev_ext);

        // Typematic repeats of the held key only count when configured to
        if (do_make && (!same_key || TYPEMATIC_COUNT != 0)) begin
            key_code_d   = data;
            key_ext_d    = ev_ext;
            key_held_d   = 1'b1;
            key_valid_d  = 1'b1;
            make_pulse_d = 1'b1;
            press_cnt_d  = press_cnt_q + CNT_W'(1);
        end

        if (do_break) begin
            break_pulse_d = 1'b1;
            if (same_key) begin
                key_held_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            nextdata_n_q  <= 1'b1;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_held_q    <= 1'b0;
            key_valid_q   <= 1'b0;
            make_pulse_q  <= 1'b0;
            break_pulse_q <= 1'b0;
            press_cnt_q   <= '0;
            ovf_sticky_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            nextdata_n_q  <= nextdata_n_d;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            key_held_q    <= key_held_d;
            key_valid_q   <= key_valid_d;
            make_pulse_q  <= make_pulse_d;
            break_pulse_q <= break_pulse_d;
            press_cnt_q   <= press_cnt_d;
            ovf_sticky_q  <= ovf_sticky_d;
        end
    end

    assign nextdata_n  = nextdata_n_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_held    = key_held_q;
    assign make_pulse  = make_pulse_q;
    assign break_pulse = break_pulse_q;
    assign press_cnt   = press_cnt_q;
    assign ovf_sticky  = ovf_sticky_q;

    logic [CNT_DIGITS*4-1:0] cnt_ext;
    logic                    show_key;

    assign cnt_ext  = (CNT_DIGITS*4)'(press_cnt_q);
    assign show_key = (BLANK_ON_RELEASE != 0) ? key_held_q : key_valid_q;

    // Digits 0-1 show the key code (blankable), the rest show press_cnt nibbles
    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        logic [3:0] nib;
        logic [7:0] dig_n;

        if (i < 2) begin : g_key
            assign nib          = key_code_q[4*i +: 4];
            assign seg[8*i +: 8] = show_key ? dig_n : 8'hFF;
        end else begin : g_cnt
            assign nib          = cnt_ext[4*(i-2) +: 4];
            assign seg[8*i +: 8] = dig_n;
        end

        hex7seg u_hex (
            .hex  (nib),
            .seg_n(dig_n)
        );
    end

endmodule
